// File: rtl/ou_display_sched.sv
// ou_display_sched
// Shares one output unit between two function results, A and B.
// Each requester hands its result over with a REQ/ACK handshake. The
// value is held in a shadow register. The scheduler then picks which
// shadow drives tc_o: either the most recently accepted result, or an
// automatic A/B alternation with a fixed dwell time.
//
// Ports
//   clk_i    system clock, rising edge
//   reset_i  synchronous active-high reset
//   req_a_i  function A request; held high until ack_a_o
//   val_a_i  function A result, two's complement, stable while requested
//   req_b_i  function B request
//   val_b_i  function B result, two's complement
//   auto_i   0: show last accepted source, 1: alternate every DWELL cycles
//   ack_a_o  one-cycle capture pulse for A
//   ack_b_o  one-cycle capture pulse for B
//   tc_o     value driven to the output unit (registered, passed unchanged)
//   src_o    source shown: 0 = A, 1 = B
//   valid_o  tc_o holds captured data (0 = blank zero)
//
// state    | meaning
// S_EMPTY  | nothing captured yet, tc_o blank
// S_SHOW_A | shadow A drives tc_o
// S_SHOW_B | shadow B drives tc_o
module ou_display_sched #(
  parameter int unsigned DWELL = 50000000,
  parameter int unsigned CNT_W = 26
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_a_i,
  input  logic [7:0] val_a_i,
  input  logic       req_b_i,
  input  logic [7:0] val_b_i,
  input  logic       auto_i,
  output logic       ack_a_o,
  output logic       ack_b_o,
  output logic [7:0] tc_o,
  output logic       src_o,
  output logic       valid_o
);

  typedef enum logic [1:0] {S_EMPTY, S_SHOW_A, S_SHOW_B} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [7:0]       sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic             va_q, va_d, vb_q, vb_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_q;
  logic             ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [7:0]       tc_q, tc_d;
  logic             src_q, src_d, valid_q, valid_d;

  logic elig_a, elig_b, grant_a, grant_b, wrap;

  always_comb begin
    // A requester still seeing its ACK sits out this edge, so it
    // always observes the pulse before it can be granted again.
    elig_a  = req_a_i & ~ack_a_q;
    elig_b  = req_b_i & ~ack_b_q;
    // rr_q = 0 gives A priority on contention.
    grant_a = elig_a & (~elig_b | ~rr_q);
    grant_b = elig_b & (~elig_a | rr_q);

    rr_d = rr_q;
    if (grant_a) rr_d = 1'b1;
    if (grant_b) rr_d = 1'b0;

    sh_a_d  = grant_a ? val_a_i : sh_a_q;
    sh_b_d  = grant_b ? val_b_i : sh_b_q;
    va_d    = va_q | grant_a;
    vb_d    = vb_q | grant_b;
    ack_a_d = grant_a;
    ack_b_d = grant_b;

    wrap  = 1'b0;
    cnt_d = cnt_q;
    if (state_q == S_EMPTY || !auto_i || auto_i != auto_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Wrap looks at the post-capture flags so a grant landing on the
    // wrap edge can be switched to immediately.
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (grant_a)      state_d = S_SHOW_A;
        else if (grant_b) state_d = S_SHOW_B;
      end
      S_SHOW_A: begin
        if (!auto_i) begin
          if (grant_b) state_d = S_SHOW_B;
        end else if (wrap && vb_d) begin
          state_d = S_SHOW_B;
        end
      end
      S_SHOW_B: begin
        if (!auto_i) begin
          if (grant_a) state_d = S_SHOW_A;
        end else if (wrap && va_d) begin
          state_d = S_SHOW_A;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    tc_d    = 8'h00;
    src_d   = 1'b0;
    valid_d = 1'b0;
    if (state_d == S_SHOW_A) begin
      tc_d    = sh_a_d;
      valid_d = 1'b1;
    end else if (state_d == S_SHOW_B) begin
      tc_d    = sh_b_d;
      src_d   = 1'b1;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_EMPTY;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      va_q    <= 1'b0;
      vb_q    <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      auto_q  <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      tc_q    <= '0;
      src_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      auto_q  <= auto_i;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      tc_q    <= tc_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign ack_a_o = ack_a_q;
  assign ack_b_o = ack_b_q;
  assign tc_o    = tc_q;
  assign src_o   = src_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_ou_display_sched.sv
module tb_ou_display_sched;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, auto_m = 1'b0;
  logic [7:0] val_a = 8'h00, val_b = 8'h00;
  logic       ack_a, ack_b, src, valid;
  logic [7:0] tc;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  ou_display_sched #(.DWELL(DWELL), .CNT_W(3)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_a_i(req_a), .val_a_i(val_a),
    .req_b_i(req_b), .val_b_i(val_b),
    .auto_i(auto_m),
    .ack_a_o(ack_a), .ack_b_o(ack_b),
    .tc_o(tc), .src_o(src), .valid_o(valid)
  );

  always #5 clk = ~clk;

  // Reference model: which source is on screen (0 none, 1 A, 2 B),
  // captured values, who was served last, and cycles spent on a source.
  int         m_shown;
  logic [7:0] m_sh [2];
  bit         m_v [2];
  bit         m_ack [2];
  int         m_last;
  int         m_dwell;
  bit         m_auto_prev;
  int         g;
  bit         ea, eb, wrapped;

  always @(posedge clk) begin
    if (reset) begin
      m_shown = 0; m_sh[0] = 0; m_sh[1] = 0; m_v[0] = 0; m_v[1] = 0;
      m_ack[0] = 0; m_ack[1] = 0; m_last = 1; m_dwell = 0; m_auto_prev = 0;
    end else begin
      ea = req_a && !m_ack[0];
      eb = req_b && !m_ack[1];
      g = -1;
      if (ea && eb) g = (m_last == 0) ? 1 : 0;
      else if (ea)  g = 0;
      else if (eb)  g = 1;
      m_ack[0] = (g == 0);
      m_ack[1] = (g == 1);
      if (g >= 0) begin
        m_last = g;
        m_sh[g] = (g == 0) ? val_a : val_b;
        m_v[g] = 1;
      end
      wrapped = 0;
      if (m_shown == 0 || !auto_m || auto_m != m_auto_prev) m_dwell = 0;
      else begin
        m_dwell++;
        if (m_dwell == DWELL) begin m_dwell = 0; wrapped = 1; end
      end
      m_auto_prev = auto_m;
      if (m_shown == 0 || !auto_m) begin
        if (g >= 0) m_shown = g + 1;
      end else if (wrapped && m_v[2 - m_shown]) begin
        m_shown = 3 - m_shown;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ack_a", {31'd0, ack_a}, {31'd0, m_ack[0]});
      check("m_ack_b", {31'd0, ack_b}, {31'd0, m_ack[1]});
      check("m_tc", {24'd0, tc}, (m_shown == 1) ? {24'd0, m_sh[0]} :
                                 (m_shown == 2) ? {24'd0, m_sh[1]} : 32'd0);
      check("m_src", {31'd0, src}, (m_shown == 2) ? 32'd1 : 32'd0);
      check("m_valid", {31'd0, valid}, (m_shown != 0) ? 32'd1 : 32'd0);
      check("m_two_acks", {31'd0, ack_a & ack_b}, 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_a = 0; req_b = 0; auto_m = 0;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int toggles;
    logic prev;
    bit found;

    // reset then idle
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rst_tc", {24'd0, tc}, 32'h00);
    check("rst_valid", {31'd0, valid}, 0);
    check("rst_src", {31'd0, src}, 0);
    cyc(20);
    check("idle_valid", {31'd0, valid}, 0);

    // single capture, manual mode
    req_a = 1; val_a = 8'hF9;
    cyc(1);
    check("cap_ack_a", {31'd0, ack_a}, 1);
    check("cap_tc", {24'd0, tc}, 32'hF9);
    check("cap_valid", {31'd0, valid}, 1);
    req_a = 0;
    cyc(1);
    check("cap_ack_a_pulse", {31'd0, ack_a}, 0);
    req_b = 1; val_b = 8'h64;
    cyc(1);
    check("capb_tc", {24'd0, tc}, 32'h64);
    check("capb_src", {31'd0, src}, 1);
    req_b = 0;
    cyc(3);

    // contention from reset release
    reset = 1; req_a = 1; req_b = 1; val_a = 8'h05; val_b = 8'h80;
    cyc(2);
    reset = 0;
    cyc(1);
    check("cont1_ack_a", {30'd0, ack_a, ack_b}, 32'b10);
    check("cont1_tc", {24'd0, tc}, 32'h05);
    cyc(1);
    check("cont2_ack_b", {30'd0, ack_a, ack_b}, 32'b01);
    check("cont2_tc", {24'd0, tc}, 32'h80);
    cyc(1);
    check("cont3_ack_a", {30'd0, ack_a, ack_b}, 32'b10);
    cyc(8);
    req_a = 0; req_b = 0;
    cyc(2);

    // auto alternation, both captured
    do_reset();
    req_a = 1; val_a = 8'h11;
    cyc(1);
    req_a = 0; req_b = 1; val_b = 8'h22;
    cyc(1);
    req_b = 0; auto_m = 1;
    cyc(1);
    toggles = 0;
    prev = src;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (src != prev) toggles++;
      prev = src;
    end
    check("auto_toggles", toggles, 4);

    // grant to B landing on the wrap edge while A is shown
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_shown == 1 && m_dwell == DWELL - 1) found = 1;
      else cyc(1);
    end
    check("wrap_found", {31'd0, found}, 1);
    req_b = 1; val_b = 8'h7F;
    cyc(1);
    check("wrap_src", {31'd0, src}, 1);
    check("wrap_tc", {24'd0, tc}, 32'h7F);
    check("wrap_ack_b", {31'd0, ack_b}, 1);
    req_b = 0;
    cyc(3);

    // reset mid-operation with REQ_A pending
    req_a = 1; val_a = 8'h33; reset = 1;
    cyc(1);
    check("mid_tc", {24'd0, tc}, 0);
    check("mid_valid", {31'd0, valid}, 0);
    check("mid_ack_a", {31'd0, ack_a}, 0);
    reset = 0;
    cyc(1);
    check("mid_rel_ack_a", {31'd0, ack_a}, 1);
    check("mid_rel_tc", {24'd0, tc}, 32'h33);
    req_a = 0;
    cyc(2);

    // only A captured in auto mode: A stays on screen
    do_reset();
    req_a = 1; val_a = 8'h80;
    cyc(1);
    req_a = 0; auto_m = 1;
    cyc(20);
    check("onlya_src", {31'd0, src}, 0);
    check("onlya_tc", {24'd0, tc}, 32'h80);
    auto_m = 0;
    cyc(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) auto_m = ~auto_m;
      if (req_a) begin
        if (ack_a && $urandom_range(0, 1) == 0) req_a = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        req_a = 1; val_a = 8'($urandom);
      end
      if (req_b) begin
        if (ack_b && $urandom_range(0, 1) == 0) req_b = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        req_b = 1; val_b = 8'($urandom);
      end
      cyc(1);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
